// File: rtl/dmux_stream_router.sv
// Purpose: registered 1-to-N valid/ready demux; each beat goes to exactly one channel (sel or round-robin).
// Latency: one cycle from the accept edge to out_valid; one beat per cycle while the target consumer is ready.
// Backpressure: in_ready follows out_ready of the held beat's channel combinationally; other channels never stall.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   mode, sel           0 = route to sel, 1 = route to rr_ptr
//   in_valid/in_ready   input handshake, in_data payload (DW bits)
//   out_valid[N]        one-hot channel strobe, out_ready[N] per-channel ready
//   out_data            payload shared by all channels
//   rr_ptr              next round-robin destination
//   drop_cnt            saturating count of beats discarded for a destination >= N
module dmux_stream_router #(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int SW = 3,   // must equal ceil(log2(N))
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] rr_ptr,
  output logic [CW-1:0] drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // One extra bit so N itself (e.g. 256 with SW=8) is representable.
  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] RR_LAST = SW'(N-1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [SW-1:0] dest;
  logic [DW-1:0] data;

  logic [SW-1:0] d;
  logic          legal;
  logic          hold_rdy;
  logic          accept;
  logic          deliver;

  assign d        = mode ? rr_ptr : sel;
  // Only reachable as illegal in select mode with a non-power-of-2 N;
  // rr_ptr never leaves 0..N-1.
  assign legal    = ({1'b0, d} < N_EXT);
  // dest only ever holds a legal channel, so this index stays in range.
  assign hold_rdy = out_ready[dest];
  assign in_ready = (state == EMPTY) | hold_rdy;
  assign accept   = in_valid & in_ready;
  assign deliver  = (state == FULL) & hold_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      dest     <= '0;
      data     <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && legal) begin
        // Covers both a load into an empty slot and a reload in the same
        // cycle as delivery, so back-to-back beats see no bubble.
        state <= FULL;
        dest  <= d;
        data  <= in_data;
        if (mode) begin
          rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + SW'(1);
        end
      end else if (deliver) begin
        state <= EMPTY;
      end

      // Dropped beat: consumed, slot untouched, counter saturates.
      if (accept && !legal && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    if (state == FULL) begin
      out_valid[dest] = 1'b1;
    end
  end

  // Holds the last beat while EMPTY; consumers must qualify with out_valid.
  assign out_data = data;

endmodule

// File: tb/tb_dmux_stream_router.sv
// Purpose: scoreboard bench for dmux_stream_router; instance a is N=8/CW=16, instance b is N=6/CW=2.
// Latency: expected beats are queued when driven and retired when the monitor sees a delivery.
// Backpressure: out_ready is driven directly per test to stall the held channel.
module tb_dmux_stream_router;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: N=8, SW=3, DW=8, CW=16
  logic        a_mode = 1'b0;
  logic [2:0]  a_sel = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [7:0]  a_in_data = '0;
  logic [7:0]  a_out_valid;
  logic [7:0]  a_out_ready = 8'hFF;
  logic [7:0]  a_out_data;
  logic [2:0]  a_rr_ptr;
  logic [15:0] a_drop_cnt;

  // Instance b: N=6, SW=3, DW=8, CW=2
  logic        b_mode = 1'b0;
  logic [2:0]  b_sel = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic [5:0]  b_out_valid;
  logic [5:0]  b_out_ready = 6'h3F;
  logic [7:0]  b_out_data;
  logic [2:0]  b_rr_ptr;
  logic [1:0]  b_drop_cnt;

  dmux_stream_router #(.DW(8), .N(8), .SW(3), .CW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .rr_ptr(a_rr_ptr), .drop_cnt(a_drop_cnt)
  );

  dmux_stream_router #(.DW(8), .N(6), .SW(3), .CW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .rr_ptr(b_rr_ptr), .drop_cnt(b_drop_cnt)
  );

  int total = 0;
  int bad = 0;
  beat_t qa[$];
  beat_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor a: retire one expected beat on every delivery.
  always @(negedge clk) begin
    if (rst_n && ((a_out_valid & a_out_ready) != 8'h00)) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_beat", 32'(a_out_valid), 32'(0));
      end else begin
        beat_t e;
        e = qa.pop_front();
        chk("a_channel", 32'(a_out_valid), 32'(8'(1) << e.ch));
        chk("a_data", 32'(a_out_data), 32'(e.dat));
      end
    end
  end

  // Monitor b
  always @(negedge clk) begin
    if (rst_n && ((b_out_valid & b_out_ready) != 6'h00)) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_beat", 32'(b_out_valid), 32'(0));
      end else begin
        beat_t e;
        e = qb.pop_front();
        chk("b_channel", 32'(b_out_valid), 32'(6'(1) << e.ch));
        chk("b_data", 32'(b_out_data), 32'(e.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 32'(0));
    chk("rst_out_data", 32'(a_out_data), 32'(0));
    chk("rst_rr_ptr", 32'(a_rr_ptr), 32'(0));
    chk("rst_drop_cnt", 32'(a_drop_cnt), 32'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 32'(1));

    // ---------------- select mode, sel=5 ----------------
    a_mode = 1'b0; a_sel = 3'd5; a_in_data = 8'hA5; a_in_valid = 1'b1;
    qa.push_back('{ch: 8'd5, dat: 8'hA5});
    at_neg();
    chk("sel_in_ready", 32'(a_in_ready), 32'(1));
    tick();
    a_in_valid = 1'b0;
    at_neg();
    chk("sel_out_valid", 32'(a_out_valid), 32'(8'b0010_0000));
    tick();
    at_neg();
    chk("sel_empty_after", 32'(a_out_valid), 32'(0));
    tick();

    // ---------------- backpressure on channel 2 ----------------
    a_out_ready = 8'hFB;
    a_sel = 3'd2; a_in_data = 8'h11; a_in_valid = 1'b1;
    qa.push_back('{ch: 8'd2, dat: 8'h11});
    tick();
    a_sel = 3'd6; a_in_data = 8'h22; a_in_valid = 1'b1;
    qa.push_back('{ch: 8'd6, dat: 8'h22});
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall_out_valid", 32'(a_out_valid), 32'(8'b0000_0100));
      chk("stall_out_data", 32'(a_out_data), 32'(8'h11));
      chk("stall_in_ready", 32'(a_in_ready), 32'(0));
      tick();
    end
    a_out_ready = 8'hFF;
    at_neg();
    chk("release_in_ready", 32'(a_in_ready), 32'(1));
    tick();
    a_in_valid = 1'b0;
    at_neg();
    chk("reload_out_valid", 32'(a_out_valid), 32'(8'b0100_0000));
    chk("reload_out_data", 32'(a_out_data), 32'(8'h22));
    tick();
    at_neg();
    chk("bp_empty_after", 32'(a_out_valid), 32'(0));
    tick();

    // ---------------- round-robin, 10 back-to-back beats ----------------
    a_mode = 1'b1; a_sel = 3'd3;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 8'(i); a_in_valid = 1'b1;
      qa.push_back('{ch: 8'(i % 8), dat: 8'(i)});
      at_neg();
      chk("rr_in_ready", 32'(a_in_ready), 32'(1));
      chk("rr_ptr_step", 32'(a_rr_ptr), 32'(i % 8));
      tick();
    end
    a_in_valid = 1'b0;
    at_neg();
    chk("rr_ptr_end", 32'(a_rr_ptr), 32'(2));
    tick();
    at_neg();
    chk("rr_drained", 32'(qa.size()), 32'(0));
    tick();

    // ---------------- illegal destination, N=6, saturating CW=2 ----------------
    b_mode = 1'b0; b_sel = 3'd7; b_out_ready = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      b_in_data = 8'(8'h70 + i); b_in_valid = 1'b1;
      at_neg();
      chk("drop_in_ready", 32'(b_in_ready), 32'(1));
      chk("drop_out_valid", 32'(b_out_valid), 32'(0));
      chk("drop_cnt_step", 32'(b_drop_cnt), 32'((i > 3) ? 3 : i));
      tick();
    end
    b_in_valid = 1'b0;
    at_neg();
    chk("drop_cnt_sat", 32'(b_drop_cnt), 32'(3));
    chk("drop_no_valid", 32'(b_out_valid), 32'(0));
    tick();

    // clear instance b state before the mid-operation reset scenario
    #1 rst_n = 1'b0;
    #2 chk("clr_drop_cnt", 32'(b_drop_cnt), 32'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- reset mid-operation on instance b ----------------
    b_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = 8'(8'h30 + i); b_in_valid = 1'b1;
      qb.push_back('{ch: 8'(i), dat: 8'(8'h30 + i)});
      tick();
    end
    b_mode = 1'b0; b_sel = 3'd7;
    for (int i = 0; i < 2; i++) begin
      b_in_data = 8'hEE; b_in_valid = 1'b1;
      tick();
    end
    b_sel = 3'd4; b_in_data = 8'h44; b_out_ready = 6'b10_1111;
    qb.push_back('{ch: 8'd4, dat: 8'h44});
    tick();
    b_in_valid = 1'b0;
    at_neg();
    chk("mid_held_valid", 32'(b_out_valid), 32'(6'b01_0000));
    chk("mid_held_data", 32'(b_out_data), 32'(8'h44));
    chk("mid_rr_ptr", 32'(b_rr_ptr), 32'(3));
    chk("mid_drop_cnt", 32'(b_drop_cnt), 32'(2));
    tick();
    #1 rst_n = 1'b0;
    #1;
    qb.delete();
    chk("arst_out_valid", 32'(b_out_valid), 32'(0));
    chk("arst_out_data", 32'(b_out_data), 32'(0));
    chk("arst_rr_ptr", 32'(b_rr_ptr), 32'(0));
    chk("arst_drop_cnt", 32'(b_drop_cnt), 32'(0));
    chk("arst_in_ready", 32'(b_in_ready), 32'(1));
    #1 rst_n = 1'b1;
    tick();
    b_out_ready = 6'h3F;
    b_mode = 1'b1; b_in_data = 8'h55; b_in_valid = 1'b1;
    qb.push_back('{ch: 8'd0, dat: 8'h55});
    tick();
    b_in_valid = 1'b0;
    at_neg();
    chk("post_rst_channel", 32'(b_out_valid), 32'(6'b00_0001));
    tick();

    // ---------------- drain and summary ----------------
    for (int i = 0; i < 20; i++) begin
      if ((qa.size() == 0) && (qb.size() == 0)) break;
      tick();
    end
    chk("final_qa_empty", 32'(qa.size()), 32'(0));
    chk("final_qb_empty", 32'(qb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
